// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: opcodes, FSM encoding, bubble NOP fields.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

  // Opcode constants of the base ISA seen in EX.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Field values the ID/EX register loads when bubble_idex is asserted.
  localparam logic [6:0] NOP_OP       = 7'b0000000;
  localparam logic       NOP_REGWRITE = 1'b0;
  localparam logic       NOP_IS_AI    = 1'b0;

  // AI launch sequencer: one bit of state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // True when an ID source operand is actually read and names the EX destination.
  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input logic [4:0] rd);
    return use_src && (src == rd);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs, AI done, and all stall/flush/AI outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; master = pipeline side that drives hazard inputs, slave = controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic [4:0]       rd_ex;
  logic [6:0]       op_ex;
  logic             regwrite_ex;
  logic             is_ai_ex;
  logic             branch_taken_ex;
  logic             ai_done;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             stall_idex;
  logic             bubble_idex;
  logic             ai_start;
  logic             ai_busy;
  logic             ai_error;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, op_ex, regwrite_ex,
           is_ai_ex, branch_taken_ex, ai_done,
    input  stall_pc, stall_ifid, flush_ifid, stall_idex, bubble_idex,
           ai_start, ai_busy, ai_error, stall_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, op_ex, regwrite_ex,
           is_ai_ex, branch_taken_ex, ai_done,
    output stall_pc, stall_ifid, flush_ifid, stall_idex, bubble_idex,
           ai_start, ai_busy, ai_error, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_stall_counter.sv
// Saturating up-counter with enable, used for stall-cycle performance monitoring.
// Latency: count reflects enables up to the previous clock edge.
// Backpressure: none; holds at all-ones once saturated.
module pipeline_hazard_ctrl_stall_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer beside IF/ID and ID/EX: load-use, taken branch, AI launch/wait/timeout.
// Latency: all hazard outputs combinational from FSM state and inputs; ai_error/stall_cnt registered.
// Backpressure: freezes PC, IF/ID, ID/EX while an AI op runs; released by ai_done or timeout.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int         AI_TIMEOUT = 64,
  parameter int         CNT_W      = 16,
  parameter logic [6:0] OP_LOAD    = OPC_LOAD
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int TO_W = $clog2(AI_TIMEOUT);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            load_use;
  logic            timeout;
  logic            stall_pc;
  logic            stall_ifid;
  logic            flush_ifid;
  logic            stall_idex;
  logic            bubble_idex;
  logic            ai_start;

  assign load_use = (hz.op_ex == OP_LOAD) && hz.regwrite_ex && (hz.rd_ex != 5'd0) &&
                    (src_hit(hz.use_rs1_id, hz.rs1_id, hz.rd_ex) ||
                     src_hit(hz.use_rs2_id, hz.rs2_id, hz.rd_ex));

  // Last permitted BUSY cycle with no completion: release and flag the error.
  assign timeout = (state == ST_BUSY) && !hz.ai_done &&
                   (to_cnt == TO_W'(AI_TIMEOUT - 1));

  // Priority: AI (launch or busy) > taken branch > load-use.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    bubble_idex = 1'b0;
    ai_start    = 1'b0;
    if (state == ST_BUSY) begin
      // On done or timeout every stall drops so the AI op leaves EX this cycle.
      if (!hz.ai_done && !timeout) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        stall_idex = 1'b1;
      end
    end else if (hz.is_ai_ex) begin
      ai_start   = 1'b1;
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      stall_idex = 1'b1;
    end else if (hz.branch_taken_ex) begin
      // PC takes the branch target, so no PC stall; the younger ops are squashed.
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (load_use) begin
      // ID/EX is not held: the bubble replaces the consumer while the load moves on.
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hz.is_ai_ex) begin
            state  <= ST_BUSY;
            to_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (hz.ai_done) begin
            state <= ST_IDLE;
          end else if (timeout) begin
            state <= ST_IDLE;
            err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pipeline_hazard_ctrl_stall_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (stall_pc),
    .cnt     (hz.stall_cnt)
  );

  assign hz.stall_pc    = stall_pc;
  assign hz.stall_ifid  = stall_ifid;
  assign hz.flush_ifid  = flush_ifid;
  assign hz.stall_idex  = stall_idex;
  assign hz.bubble_idex = bubble_idex;
  assign hz.ai_start    = ai_start;
  assign hz.ai_busy     = (state == ST_BUSY);
  assign hz.ai_error    = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected outputs queued at drive time.
// Latency: expected combinational outputs compared mid-cycle, stall count vs. a saturating model.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;

  // Output vector bit order: stall_pc stall_ifid flush_ifid stall_idex bubble_idex ai_start ai_busy ai_error
  localparam logic [7:0] O_NONE   = 8'b0000_0000;
  localparam logic [7:0] O_LU     = 8'b1100_1000;
  localparam logic [7:0] O_BR     = 8'b0010_1000;
  localparam logic [7:0] O_LAUNCH = 8'b1101_0100;
  localparam logic [7:0] O_BUSY   = 8'b1101_0010;
  localparam logic [7:0] O_REL    = 8'b0000_0010;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic [6:0] op;
    logic       rw;
    logic       ai;
    logic       br;
    logic       done;
  } in_t;

  typedef struct {
    string            tag;
    logic [7:0]       o;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_err;
  in_t              s;
  in_t              idle_in;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .AI_TIMEOUT (8),
    .CNT_W      (CNT_W),
    .OP_LOAD    (7'b0000011)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input in_t i);
    hz.rs1_id          = i.rs1;
    hz.rs2_id          = i.rs2;
    hz.use_rs1_id      = i.u1;
    hz.use_rs2_id      = i.u2;
    hz.rd_ex           = i.rd;
    hz.op_ex           = i.op;
    hz.regwrite_ex     = i.rw;
    hz.is_ai_ex        = i.ai;
    hz.branch_taken_ex = i.br;
    hz.ai_done         = i.done;
  endtask

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle, advance.
  task automatic cyc(input in_t i, input logic [7:0] eo, input string tag);
    exp_t e;
    exp_t g;
    logic [7:0] obs;
    apply(i);
    e.tag = tag;
    e.o   = eo | {7'b0, exp_err};
    e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    g   = sb.pop_front();
    obs = {hz.stall_pc, hz.stall_ifid, hz.flush_ifid, hz.stall_idex,
           hz.bubble_idex, hz.ai_start, hz.ai_busy, hz.ai_error};
    chk({g.tag, "/out"}, 32'(obs), 32'(g.o));
    chk({g.tag, "/cnt"}, 32'(hz.stall_cnt), 32'(g.cnt));
    if (eo[7] && reset_n && (exp_cnt != '1)) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk      = 1'b0;
    reset_n  = 1'b0;
    checks   = 0;
    failures = 0;
    exp_cnt  = '0;
    exp_err  = 1'b0;
    idle_in  = '{rs1: 5'd1, rs2: 5'd2, u1: 1'b0, u2: 1'b0, rd: 5'd0,
                 op: 7'b0010011, rw: 1'b0, ai: 1'b0, br: 1'b0, done: 1'b0};

    cyc(idle_in, O_NONE, "reset");
    reset_n = 1'b1;
    cyc(idle_in, O_NONE, "idle");

    // Load-use through rs1, then the load has left EX.
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd5; s.rw = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1;
    cyc(s, O_LU, "lu_rs1");
    cyc(idle_in, O_NONE, "lu_after");
    // Load-use through rs2.
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd7; s.rw = 1'b1; s.rs2 = 5'd7; s.u2 = 1'b1;
    cyc(s, O_LU, "lu_rs2");

    // Near misses: rd=0, operand not used, non-load, no regwrite, register mismatch.
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd0; s.rw = 1'b1; s.rs1 = 5'd0; s.u1 = 1'b1;
    cyc(s, O_NONE, "lu_rd0");
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd5; s.rw = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b0;
    cyc(s, O_NONE, "lu_nouse");
    s = idle_in; s.op = 7'b0110011; s.rd = 5'd5; s.rw = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1;
    cyc(s, O_NONE, "lu_notload");
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd5; s.rw = 1'b0; s.rs1 = 5'd5; s.u1 = 1'b1;
    cyc(s, O_NONE, "lu_norw");
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd5; s.rw = 1'b1; s.rs1 = 5'd6; s.u1 = 1'b1;
    cyc(s, O_NONE, "lu_miss");

    // Branch alone, and branch overriding a live load-use.
    s = idle_in; s.br = 1'b1;
    cyc(s, O_BR, "br");
    s = idle_in; s.op = 7'b0000011; s.rd = 5'd5; s.rw = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1; s.br = 1'b1;
    cyc(s, O_BR, "br_over_lu");

    // ai_done in IDLE has no effect.
    s = idle_in; s.done = 1'b1;
    cyc(s, O_NONE, "done_idle");

    // AI op completing with ai_done in cycle 4; a branch in BUSY is ignored.
    s = idle_in; s.ai = 1'b1;
    cyc(s, O_LAUNCH, "ai_c0");
    cyc(s, O_BUSY, "ai_c1");
    s.br = 1'b1;
    cyc(s, O_BUSY, "ai_c2_br");
    s.br = 1'b0;
    cyc(s, O_BUSY, "ai_c3");
    s.done = 1'b1;
    cyc(s, O_REL, "ai_c4_done");
    cyc(idle_in, O_NONE, "ai_after");

    // Two timeouts: error rises after 8 stalled cycles and stays; counter saturates.
    for (int r = 0; r < 2; r++) begin
      s = idle_in; s.ai = 1'b1;
      cyc(s, O_LAUNCH, "to_launch");
      for (int k = 0; k < 7; k++) cyc(s, O_BUSY, "to_busy");
      cyc(s, O_REL, "to_release");
      exp_err = 1'b1;
      cyc(idle_in, O_NONE, "to_err_sticky");
      cyc(idle_in, O_NONE, "to_idle");
    end

    // Reset during the second BUSY cycle: everything clears asynchronously.
    s = idle_in; s.ai = 1'b1;
    cyc(s, O_LAUNCH, "rb_launch");
    cyc(s, O_BUSY, "rb_busy1");
    reset_n = 1'b0;
    exp_cnt = '0;
    exp_err = 1'b0;
    cyc(idle_in, O_NONE, "rb_in_reset");
    reset_n = 1'b1;
    cyc(idle_in, O_NONE, "rb_post1");
    cyc(idle_in, O_NONE, "rb_post2");

    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core with AI extension.
- Sits beside the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards and taken-branch flushes, and launches multi-cycle AI ops via a start/done handshake while freezing the front end.
- Counts stall cycles for performance monitoring.

Parameters:
- AI_TIMEOUT, 64, max BUSY cycles waiting for ai_done before forced abort (>=2).
- CNT_W, 16, width of saturating stall-cycle counter.
- OP_LOAD, 7'b0000011, opcode treated as load in EX.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_id  in  5  ID source reg 1.
- rs2_id  in  5  ID source reg 2.
- use_rs1_id  in  1  ID instruction reads rs1.
- use_rs2_id  in  1  ID instruction reads rs2.
- rd_ex  in  5  EX destination reg.
- op_ex  in  7  EX opcode.
- regwrite_ex  in  1  EX writes rd.
- is_ai_ex  in  1  EX holds an AI instruction.
- branch_taken_ex  in  1  EX resolved taken branch/jump.
- ai_done  in  1  AI unit completion pulse.
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- flush_ifid  out  1  zero IF/ID (squash).
- stall_idex  out  1  hold ID/EX (drives its stall input).
- bubble_idex  out  1  load NOP into ID/EX (regwrite/is_ai/op forced 0).
- ai_start  out  1  one-cycle launch pulse to AI unit.
- ai_busy  out  1  FSM in BUSY.
- ai_error  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, timeout counter=0, ai_error=0, stall_cnt=0.
  - All combinational outputs follow from state IDLE and the inputs.
- FSM states: IDLE, BUSY.
- IDLE, is_ai_ex=1:
  - ai_start=1; stall_pc=stall_ifid=stall_idex=1; next BUSY; counter cleared.
- BUSY, ai_done=0:
  - stall_pc=stall_ifid=stall_idex=1; counter+1.
- BUSY, ai_done=1:
  - All stalls 0; the AI instruction leaves EX this cycle; next IDLE.
- BUSY timeout (counter==AI_TIMEOUT-1 and ai_done=0):
  - Set ai_error (sticky until reset); release as for ai_done; next IDLE.
- ai_done is ignored in IDLE.
- ai_start can never assert in consecutive cycles.
- Load-use (IDLE, no AI in EX):
  - Condition: op_ex==OP_LOAD and regwrite_ex and rd_ex!=0 and ((use_rs1_id and rs1_id==rd_ex) or (use_rs2_id and rs2_id==rd_ex)).
  - Response: stall_pc=stall_ifid=1, bubble_idex=1, stall_idex=0.
  - Exactly one bubble per load; the next cycle has the load out of EX.
- Branch (IDLE, no AI in EX):
  - branch_taken_ex=1 gives flush_ifid=1 and bubble_idex=1; stall_pc=0 (PC takes target).
  - Branch overrides load-use in the same cycle, so no stall.
- Priority: AI (IDLE-launch or BUSY) > branch > load-use > none.
- bubble_idex and stall_idex are never both 1.
- flush_ifid and stall_ifid are never both 1.
- Outputs are combinational from state and current inputs; zero added latency.
- ai_busy = (state==BUSY).
- stall_cnt: increments each cycle stall_pc=1, saturates at all-ones.
- Reset mid-BUSY: returns to IDLE immediately with no ai_start; the AI unit is reset by the same reset_n.

Decomposition:
- Shared package (core_pkg): OP_LOAD and other opcode constants, FSM state encoding (2 states, 1 bit), and the NOP field values used for bubble_idex.
- One natural sub-module: hazard_stall_counter, a saturating CNT_W counter with enable.

Test Plan:
- Load-use: EX op=0000011, rd=5, regwrite=1; ID rs1=5, use_rs1=1 -> one cycle with stall_pc=1, bubble_idex=1, stall_idex=0; next cycle no stall; stall_cnt=1.
- rd=0 / no use: same as load-use but rd_ex=0, or use_rs1=0 -> no stall, no bubble.
- Branch + load-use same cycle: branch_taken_ex=1 with load-use condition true -> flush_ifid=1, bubble_idex=1, stall_pc=0.
- AI op: is_ai_ex=1, ai_done pulsed 4 cycles after start -> ai_start single pulse in cycle 0; stalls high cycles 0-3; release in cycle 4; stall_cnt=4.
- Timeout: AI_TIMEOUT=8, no ai_done -> ai_error rises after 8 stalled cycles in total; FSM returns to IDLE; ai_error stays 1 until reset_n=0.
- Reset mid-BUSY: reset_n=0 during cycle 2 of BUSY -> ai_busy=0, all stalls 0, stall_cnt=0 immediately (async); no spurious ai_start after release.
